// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs RV32I fields into words and streams them into imem at sequential addresses
// Optional immediate range checking is enabled by defining IMM_CHECK_EN.
module instr_encoder_loader #(
    parameter int AW    = 32,
    parameter int DEPTH = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic          in_last_i,
    input  logic [2:0]    cls_i,
    input  logic [2:0]    funct3_i,
    input  logic [6:0]    funct7_i,
    input  logic [4:0]    rd_i,
    input  logic [4:0]    rs1_i,
    input  logic [4:0]    rs2_i,
    input  logic [31:0]   imm_i,
    output logic          imem_we_o,
    output logic [AW-1:0] imem_addr_o,
    output logic [31:0]   imem_wdata_o,
    output logic [AW-1:0] count_o,
    output logic          done_o,
    output logic          err_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [AW-1:0] DEPTH_W = AW'(DEPTH);

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] count_q, count_d;
    logic          we_q, we_d;
    logic [AW-1:0] waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          accept;
    logic          load_start;

    function automatic logic [31:0] encode(
        input logic [2:0]  cls,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (cls)
            3'd0: w = {f7, rs2, rs1, f3, rd, 7'b0110011};
            3'd1: begin
                // shifts carry funct7 and a 5-bit shamt in the upper immediate slot
                if (f3 == 3'b001 || f3 == 3'b101)
                    w = {f7, imm[4:0], rs1, f3, rd, 7'b0010011};
                else
                    w = {imm[11:0], rs1, f3, rd, 7'b0010011};
            end
            3'd2:    w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            3'd3:    w = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
            3'd4:    w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            3'd5:    w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            3'd6:    w = {imm[31:12], rd, 7'b0110111};
            default: w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
        endcase
        return w;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start_i) state_d = S_RUN;
            S_RUN:  if (accept && (in_last_i || (count_q + AW'(1)) == DEPTH_W)) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_o = (state_q == S_RUN) && (count_q < DEPTH_W);
        done_o     = (state_q == S_DONE);
    end

    assign accept     = in_valid_i && in_ready_o;
    assign load_start = (state_q == S_IDLE) && start_i;

    always_comb begin
        addr_d  = addr_q;
        count_d = count_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (load_start) begin
            addr_d  = base_addr_i & ~AW'(3);
            count_d = '0;
        end else if (accept) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = encode(cls_i, funct3_i, funct7_i, rd_i, rs1_i, rs2_i, imm_i);
            addr_d  = addr_q + AW'(4);
            count_d = count_q + AW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            count_q <= count_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we_o    = we_q;
    assign imem_addr_o  = waddr_q;
    assign imem_wdata_o = wdata_q;
    assign count_o      = count_q;

`ifdef IMM_CHECK_EN
    logic imm_bad;
    logic err_q, err_d;

    always_comb begin
        imm_bad = 1'b0;
        case (cls_i)
            3'd1, 3'd2, 3'd3, 3'd4: imm_bad = (imm_i[31:11] != {21{imm_i[11]}});
            3'd5: imm_bad = (imm_i[31:12] != {20{imm_i[12]}}) || imm_i[0];
            3'd6: imm_bad = (imm_i[11:0] != 12'd0);
            3'd7: imm_bad = (imm_i[31:20] != {12{imm_i[20]}}) || imm_i[0];
            default: imm_bad = 1'b0;
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (load_start)            err_d = 1'b0;
        else if (accept && imm_bad) err_d = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_d;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb/tb_instr_encoder_loader.sv - randomized self-checking bench for instr_encoder_loader
module tb_instr_encoder_loader;

    localparam int AW    = 32;
    localparam int DEPTH = 4;
`ifdef IMM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    typedef struct {
        bit [2:0]  cls;
        bit [2:0]  f3;
        bit [6:0]  f7;
        bit [4:0]  rd;
        bit [4:0]  rs1;
        bit [4:0]  rs2;
        bit [31:0] imm;
        bit        last;
    } req_t;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [AW-1:0] base_addr_i;
    logic          in_valid_i;
    logic          in_ready_o;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [31:0]   imem_wdata_o;
    logic [AW-1:0] count_o;
    logic          done_o;
    logic          err_o;
    req_t          cur;

    always #5 clk = ~clk;

    instr_encoder_loader #(.AW(AW), .DEPTH(DEPTH)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_last_i   (cur.last),
        .cls_i       (cur.cls),
        .funct3_i    (cur.f3),
        .funct7_i    (cur.f7),
        .rd_i        (cur.rd),
        .rs1_i       (cur.rs1),
        .rs2_i       (cur.rs2),
        .imm_i       (cur.imm),
        .imem_we_o   (imem_we_o),
        .imem_addr_o (imem_addr_o),
        .imem_wdata_o(imem_wdata_o),
        .count_o     (count_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: a load is a run of up to DEPTH accepted requests, each becoming one
    // write at base + 4*k one cycle later.
    bit          m_run, m_fin, m_err;
    int unsigned m_cnt;
    bit [31:0]   m_addr;
    bit          e_we, e_done;
    bit [31:0]   e_addr, e_wdata;
    bit [31:0]   seen[$];
    int          done_pulses;
    req_t        rq[$];

    function automatic bit [31:0] ref_enc(req_t r);
        int unsigned f3 = r.f3, f7 = r.f7, rd = r.rd, rs1 = r.rs1, rs2 = r.rs2, u = r.imm;
        int unsigned w;
        case (r.cls)
            3'd0: w = (f7 << 25) + (rs2 << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h33;
            3'd1: begin
                if (f3 == 1 || f3 == 5)
                    w = (f7 << 25) + ((u % 32) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h13;
                else
                    w = ((u % 4096) << 20) + (rs1 << 15) + (f3 << 12) + (rd << 7) + 32'h13;
            end
            3'd2: w = ((u % 4096) << 20) + (rs1 << 15) + (2 << 12) + (rd << 7) + 32'h03;
            3'd3: w = ((u % 4096) << 20) + (rs1 << 15) + (rd << 7) + 32'h67;
            3'd4: w = (((u / 32) % 128) << 25) + (rs2 << 20) + (rs1 << 15) + (2 << 12)
                      + ((u % 32) << 7) + 32'h23;
            3'd5: w = (((u / 4096) % 2) << 31) + (((u / 32) % 64) << 25) + (rs2 << 20) + (rs1 << 15)
                      + (f3 << 12) + (((u / 2) % 16) << 8) + (((u / 2048) % 2) << 7) + 32'h63;
            3'd6: w = (u - (u % 4096)) + (rd << 7) + 32'h37;
            default: w = (((u / 1048576) % 2) << 31) + (((u / 2) % 1024) << 21) + (((u / 2048) % 2) << 20)
                         + (((u / 4096) % 256) << 12) + (rd << 7) + 32'h6f;
        endcase
        return w;
    endfunction

    function automatic bit ref_bad(req_t r);
        int s = signed'(r.imm);
        case (r.cls)
            3'd1, 3'd2, 3'd3, 3'd4: return (s < -2048) || (s > 2047);
            3'd5: return (s < -4096) || (s > 4095) || (r.imm % 2 != 0);
            3'd6: return (r.imm % 4096) != 0;
            3'd7: return (s < -1048576) || (s > 1048575) || (r.imm % 2 != 0);
            default: return 1'b0;
        endcase
    endfunction

    function automatic req_t mk(bit [2:0] cls, bit [2:0] f3, bit [6:0] f7, bit [4:0] rd,
                                bit [4:0] rs1, bit [4:0] rs2, bit [31:0] imm, bit last);
        req_t r;
        r.cls = cls; r.f3 = f3; r.f7 = f7; r.rd = rd;
        r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.last = last;
        return r;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.cls = 3'($urandom); r.f3 = 3'($urandom); r.f7 = 7'($urandom);
        r.rd = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom);
        r.last = 1'b0;
        case ($urandom_range(0, 3))
            0: r.imm = $urandom;
            1: r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            2: r.imm = $urandom & 32'hFFFFF000;
            default: r.imm = (32'($urandom_range(0, 2097151)) - 32'd1048576) & 32'hFFFFFFFE;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        m_run = 0; m_fin = 0; m_err = 0; m_cnt = 0; m_addr = 0;
        e_we = 0; e_done = 0; e_addr = 0; e_wdata = 0;
    endtask

    task automatic step(output bit acc);
        bit fin_n;
        check("in_ready", in_ready_o, m_run && (m_cnt < DEPTH));
        check("imem_we", imem_we_o, e_we);
        if (e_we) begin
            check("imem_addr", imem_addr_o, e_addr);
            check("imem_wdata", imem_wdata_o, e_wdata);
            seen.push_back(imem_wdata_o);
        end
        check("done", done_o, e_done);
        if (done_o) done_pulses++;
        check("count", count_o, m_cnt);
        check("err", err_o, m_err);
        acc   = in_valid_i && m_run && (m_cnt < DEPTH);
        e_we  = 0;
        fin_n = 0;
        if (!m_run && !m_fin && start_i) begin
            m_run = 1; m_cnt = 0; m_err = 0;
            m_addr = base_addr_i - (base_addr_i % 4);
        end else if (acc) begin
            e_we = 1; e_addr = m_addr; e_wdata = ref_enc(cur);
            if (CHK && ref_bad(cur)) m_err = 1;
            m_cnt++;
            m_addr += 4;
            if (cur.last || m_cnt == DEPTH) begin
                m_run = 0;
                fin_n = 1;
            end
        end
        m_fin  = fin_n;
        e_done = fin_n;
        @(posedge clk);
        #1;
    endtask

    task automatic run_load(input bit [31:0] base, input int gap_pct);
        bit acc;
        int idx = 0;
        int cyc = 0;
        seen.delete();
        done_pulses = 0;
        cur = rand_req();
        in_valid_i = 0;
        base_addr_i = base;
        start_i = 1;
        step(acc);
        start_i = 0;
        while ((m_run || m_fin || e_we) && cyc < 200) begin
            if (m_run && idx < rq.size() && $urandom_range(0, 99) >= gap_pct) begin
                cur = rq[idx];
                in_valid_i = 1;
            end else begin
                cur = rand_req();
                cur.last = 1'($urandom);
                in_valid_i = m_run ? 1'b0 : 1'($urandom);
            end
            start_i = m_run && ($urandom_range(0, 9) == 0);
            base_addr_i = $urandom;
            step(acc);
            if (acc) idx++;
            cyc++;
        end
        check("load_ended", cyc < 200, 1);
        start_i = 0;
        for (int k = 0; k < 3; k++) begin
            cur = rand_req();
            in_valid_i = 1'($urandom);
            step(acc);
        end
        in_valid_i = 0;
    endtask

    task automatic chk_zero(input string pfx);
        check({pfx, "_in_ready"}, in_ready_o, 0);
        check({pfx, "_we"}, imem_we_o, 0);
        check({pfx, "_done"}, done_o, 0);
        check({pfx, "_err"}, err_o, 0);
        check({pfx, "_addr"}, imem_addr_o, 0);
        check({pfx, "_wdata"}, imem_wdata_o, 0);
        check({pfx, "_count"}, count_o, 0);
    endtask

    initial begin
        bit acc;
        rst_ni = 0; start_i = 0; base_addr_i = 0; in_valid_i = 0;
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_ni = 1;

        // back-to-back, five requests, DEPTH stops the load after four
        rq = '{mk(0, 0, 0, 3, 1, 2, 32'd0, 0), mk(1, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 0),
               mk(4, 0, 0, 0, 1, 2, 32'd8, 0), mk(5, 0, 0, 0, 1, 2, 32'hFFFFFFFC, 0),
               mk(7, 0, 0, 1, 0, 0, 32'd8, 0)};
        run_load(32'h100, 0);
        check("a_writes", seen.size(), 4);
        if (seen.size() == 4) begin
            check("a_r_word", seen[0], 32'h002081B3);
            check("a_addi_word", seen[1], 32'hFFF00093);
            check("a_sw_word", seen[2], 32'h0020A423);
            check("a_beq_word", seen[3], 32'hFE208EE3);
        end
        check("a_done_pulses", done_pulses, 1);
        check("a_count", count_o, 4);

        // in_last on third, unaligned base, out-of-range I immediate
        rq = '{mk(7, 0, 0, 1, 0, 0, 32'd8, 0), mk(1, 0, 0, 1, 0, 0, 32'h800, 0),
               mk(0, 0, 0, 3, 1, 2, 32'd0, 1)};
        run_load(32'h203, 0);
        check("b_writes", seen.size(), 3);
        if (seen.size() == 3) begin
            check("b_jal_word", seen[0], 32'h008000EF);
            check("b_addi800_word", seen[1], 32'h80000093);
        end
        check("b_done_pulses", done_pulses, 1);
        check("b_count", count_o, 3);
        check("b_err", err_o, CHK);

        for (int it = 0; it < 40; it++) begin
            int n = $urandom_range(1, 6);
            rq.delete();
            for (int j = 0; j < n; j++) rq.push_back(rand_req());
            rq[n-1].last = 1;
            run_load((it % 4 == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom,
                     (it % 3 == 0) ? 0 : 30);
            check("rand_done_pulses", done_pulses, 1);
        end

        // reset asserted while a request is being offered, before the accepting edge
        rq = '{rand_req(), rand_req()};
        cur = rand_req();
        base_addr_i = 32'h40;
        start_i = 1;
        step(acc);
        start_i = 0;
        check("rst_pre_ready", in_ready_o, 1);
        cur = rq[0];
        in_valid_i = 1;
        #3;
        rst_ni = 0;
        #1;
        chk_zero("rst_async");
        @(posedge clk);
        #1;
        chk_zero("rst_next");
        in_valid_i = 0;
        rst_ni = 1;
        model_reset();

        rq = '{mk(6, 0, 0, 5, 0, 0, 32'h12345000, 1)};
        run_load(32'h0, 0);
        check("post_rst_writes", seen.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
